add16_result_fifo: RTL and testbench

- Downstream stage of the 16-bit ripple-carry adder in the data pipeline.
- Captures each adder result (16-bit sum plus carry-out) into a small show-ahead FIFO.
- Presents results to the next consumer over a valid/ready handshake.
- Keeps a saturating count of accepted results whose carry-out was 1, for overflow monitoring.

---
 rtl/add16_result_fifo_if.sv | 31 +++
 rtl/add16_result_fifo.sv | 118 +++++++++++
 tb/tb_add16_result_fifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/add16_result_fifo_if.sv
// Handshake bundle between the 16-bit adder, the result FIFO and its consumer.
// Master is the producer/consumer side; slave is the FIFO itself.
interface add16_result_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;

    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/add16_result_fifo.sv
// Show-ahead result FIFO behind the 16-bit adder with a saturating carry counter.
// Optional zero-result flag and counter enabled by `define ADD16_ZERO_FLAG_EN.
module add16_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    add16_result_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         carry_cnt,
    input  logic                     cnt_clr
`ifdef ADD16_ZERO_FLAG_EN
    ,
    output logic                     out_zero,
    output logic [CNT_W-1:0]         zero_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [16:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
    logic             push, pop;
    logic             not_full, not_empty;

    assign not_full  = (level_q != FULL);
    assign not_empty = (level_q != '0);
    assign push      = bus.in_valid && not_full;
    assign pop       = not_empty && bus.out_ready;

    assign bus.in_ready  = not_full;
    assign bus.out_valid = not_empty;
    // Head is forced to zero when empty so stale storage never leaks out.
    assign bus.out_data  = not_empty ? mem_q[rd_ptr_q] : '0;

    assign level     = level_q;
    assign carry_cnt = carry_cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if (cnt_clr) begin
            carry_cnt_d = '0;
        end else if (push && bus.in_carry && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    // Storage needs no reset; reads are masked by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_carry, bus.in_sum};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

`ifdef ADD16_ZERO_FLAG_EN
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic             zero_push;

    assign zero_push = push && (bus.in_sum == 16'h0) && !bus.in_carry;
    assign out_zero  = not_empty && (bus.out_data == 17'h0);
    assign zero_cnt  = zero_cnt_q;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (cnt_clr) begin
            zero_cnt_d = '0;
        end else if (zero_push && (zero_cnt_q != '1)) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_add16_result_fifo.sv
// Scoreboard bench for add16_result_fifo: a negedge monitor models the FIFO
// and counter, directed sequences walk fill, stream, saturation and reset.
module tb_add16_result_fifo;

    logic       clk;
    logic       rst_n;
    logic [3:0] level;
    logic [7:0] carry_cnt;
    logic       cnt_clr;
`ifdef ADD16_ZERO_FLAG_EN
    logic       out_zero;
    logic [7:0] zero_cnt;
`endif

    int n_cmp;
    int n_err;
    logic [16:0] sb_q[$];
    int mcnt;
    int zcnt;

    add16_result_fifo_if bif ();

    add16_result_fifo #(
        .DEPTH(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bif),
        .level    (level),
        .carry_cnt(carry_cnt),
        .cnt_clr  (cnt_clr)
`ifdef ADD16_ZERO_FLAG_EN
        ,
        .out_zero (out_zero),
        .zero_cnt (zero_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Monitor: inputs are stable mid-cycle, so decide the coming edge's
    // push/pop here and compare the DUT against the model first.
    always @(negedge clk) begin
        int sz;
        logic do_push, do_pop;
        if (!rst_n) begin
            sb_q.delete();
            mcnt = 0;
            zcnt = 0;
        end else begin
            sz = sb_q.size();
            chk("level", 32'(level), 32'(sz));
            chk("in_ready", 32'(bif.in_ready), 32'(sz != 4));
            chk("out_valid", 32'(bif.out_valid), 32'(sz != 0));
            chk("out_data", 32'(bif.out_data), (sz != 0) ? 32'(sb_q[0]) : 0);
            chk("carry_cnt", 32'(carry_cnt), 32'(mcnt));
`ifdef ADD16_ZERO_FLAG_EN
            chk("out_zero", 32'(out_zero),
                32'((sz != 0) && (sb_q[0] == 17'h0)));
            chk("zero_cnt", 32'(zero_cnt), 32'(zcnt));
`endif
            do_pop  = (sz != 0) && bif.out_ready;
            do_push = bif.in_valid && (sz != 4);
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) sb_q.push_back({bif.in_carry, bif.in_sum});
            if (cnt_clr) begin
                mcnt = 0;
                zcnt = 0;
            end else if (do_push) begin
                if (bif.in_carry && mcnt < 255) mcnt++;
                if (!bif.in_carry && bif.in_sum == 16'h0 && zcnt < 255) zcnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [16:0] drain_exp [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        mcnt  = 0;
        zcnt  = 0;
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_sum    = 16'h0;
        bif.in_carry  = 1'b0;
        bif.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bif.in_ready), 1);
        chk("rst_out_valid", 32'(bif.out_valid), 0);
        #11 rst_n = 1'b1;
        step(1);
        chk("idle_in_ready", 32'(bif.in_ready), 1);
        chk("idle_out_valid", 32'(bif.out_valid), 0);
        chk("idle_out_data", 32'(bif.out_data), 0);
        chk("idle_level", 32'(level), 0);
        chk("idle_carry_cnt", 32'(carry_cnt), 0);

        // Single push, one-cycle latency.
        bif.in_valid = 1'b1;
        bif.in_sum   = 16'h1234;
        bif.in_carry = 1'b0;
        step(1);
        bif.in_valid = 1'b0;
        chk("one_valid", 32'(bif.out_valid), 1);
        chk("one_data", 32'(bif.out_data), 32'h01234);
        chk("one_level", 32'(level), 1);
        step(2);
        chk("one_stable", 32'(bif.out_data), 32'h01234);
        bif.out_ready = 1'b1;
        step(1);
        bif.out_ready = 1'b0;
        chk("one_drained", 32'(level), 0);

        // Fill to DEPTH, then a refused push.
        for (int i = 1; i <= 4; i++) begin
            bif.in_valid = 1'b1;
            bif.in_sum   = 16'(i);
            bif.in_carry = (i != 2);
            step(1);
        end
        bif.in_sum   = 16'hFFFF;
        bif.in_carry = 1'b1;
        chk("full_in_ready", 32'(bif.in_ready), 0);
        chk("full_level", 32'(level), 4);
        chk("full_carry_cnt", 32'(carry_cnt), 3);
        step(2);
        chk("refused_level", 32'(level), 4);
        chk("refused_carry_cnt", 32'(carry_cnt), 3);
        bif.in_valid = 1'b0;
        drain_exp[0] = 17'h10001;
        drain_exp[1] = 17'h00002;
        drain_exp[2] = 17'h10003;
        drain_exp[3] = 17'h10004;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(bif.out_data), 32'(drain_exp[i]));
            step(1);
        end
        bif.out_ready = 1'b0;
        chk("drain_empty", 32'(bif.out_valid), 0);
        chk("drain_data0", 32'(bif.out_data), 0);

        // Streaming with simultaneous push/pop.
        bif.in_valid  = 1'b1;
        bif.out_ready = 1'b1;
        bif.in_carry  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bif.in_sum = 16'h0100 + 16'(i);
            step(1);
            chk("stream_level", 32'(level), 1);
            chk("stream_head", 32'(bif.out_data), 32'h00100 + 32'(i));
        end
        bif.in_valid = 1'b0;
        step(1);
        bif.out_ready = 1'b0;
        chk("stream_end", 32'(level), 0);

        // Zero-valued results and carry counter saturation.
        bif.in_valid = 1'b1;
        bif.in_sum   = 16'h0000;
        bif.in_carry = 1'b0;
        step(1);
        bif.out_ready = 1'b1;
        bif.in_carry  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bif.in_sum = 16'(i * 7);
            step(1);
        end
        chk("sat_carry_cnt", 32'(carry_cnt), 255);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        bif.in_valid = 1'b0;
        chk("clr_priority", 32'(carry_cnt), 0);
        step(2);
        bif.out_ready = 1'b0;
        chk("post_sat_level", 32'(level), 0);

        // Asynchronous reset mid-operation at level 3.
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.in_sum   = 16'hA000 + 16'(i);
            bif.in_carry = 1'b1;
            step(1);
        end
        bif.in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bif.out_valid), 0);
        chk("async_level", 32'(level), 0);
        chk("async_out_data", 32'(bif.out_data), 0);
        chk("async_carry_cnt", 32'(carry_cnt), 0);
        sb_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1);
        bif.in_valid = 1'b1;
        bif.in_sum   = 16'hBEEF;
        bif.in_carry = 1'b0;
        step(1);
        bif.in_sum   = 16'hCAFE;
        bif.in_carry = 1'b1;
        step(1);
        bif.in_valid = 1'b0;
        chk("after_rst_first", 32'(bif.out_data), 32'h0BEEF);
        bif.out_ready = 1'b1;
        step(1);
        chk("after_rst_second", 32'(bif.out_data), 32'h1CAFE);
        step(2);
        bif.out_ready = 1'b0;
        chk("final_level", 32'(level), 0);
        chk("final_queue", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
